// File: rtl/multiword_add_seq_pkg.sv
// Shared constants for the sequential multi-word adder: word width, counter width
// and FSM state encoding.
package multiword_add_seq_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/fullAdder_16bit.sv
// 16-bit adder with carry-in. Reports the carry-out, the result sign and two's-complement overflow.
// Purely combinational, with no backpressure.
module fullAdder_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Z,
  output logic        Carry,
  output logic        Sign,
  output logic        Overflow
);

  assign {Carry, Z} = {1'b0, A} + {1'b0, B} + {16'd0, Cin};
  assign Sign       = Z[15];
  assign Overflow   = (A[15] == B[15]) && (Z[15] != A[15]);

endmodule

// File: rtl/multiword_add_seq.sv
// Adds two NWORDS x 16-bit operands one word per accept, least-significant word first.
// Latency is one cycle per word. A stalled output holds and drops in_ready. Whole-result flags are registered on the last handshake.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cin_init,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_word,
  input  logic [WORD_W-1:0] b_word,
  output logic [WORD_W-1:0] sum_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              sign,
  output logic              zero,
  output logic              carry,
  output logic              parity,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] NW_C   = CNT_W'(NWORDS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NWORDS - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cy_q, cy_d;
  logic              zacc_q, zacc_d;
  logic              pacc_q, pacc_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              ov_q, ov_d;
  logic              last_q, last_d;
  logic              ms_sign_q, ms_sign_d;
  logic              ms_ovf_q, ms_ovf_d;
  logic              f_sign_q, f_sign_d;
  logic              f_zero_q, f_zero_d;
  logic              f_carry_q, f_carry_d;
  logic              f_parity_q, f_parity_d;
  logic              f_ovf_q, f_ovf_d;

  logic [WORD_W-1:0] add_z;
  logic              add_cy, add_sign, add_ovf;
  logic              in_ready_c, accept, hshake;

  fullAdder_16bit u_add (
    .A        (a_word),
    .B        (b_word),
    .Cin      (cy_q),
    .Z        (add_z),
    .Carry    (add_cy),
    .Sign     (add_sign),
    .Overflow (add_ovf)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cy_d       = cy_q;
    zacc_d     = zacc_q;
    pacc_d     = pacc_q;
    sum_d      = sum_q;
    ov_d       = ov_q;
    last_d     = last_q;
    ms_sign_d  = ms_sign_q;
    ms_ovf_d   = ms_ovf_q;
    f_sign_d   = f_sign_q;
    f_zero_d   = f_zero_q;
    f_carry_d  = f_carry_q;
    f_parity_d = f_parity_q;
    f_ovf_d    = f_ovf_q;

    in_ready_c = (state_q == S_RUN) && (cnt_q < NW_C) && (!ov_q || out_ready);
    accept     = in_valid && in_ready_c;
    hshake     = ov_q && out_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cy_d    = cin_init;
          cnt_d   = '0;
          zacc_d  = 1'b1;
          pacc_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          sum_d  = add_z;
          ov_d   = 1'b1;
          last_d = (cnt_q == LAST_C);
          cy_d   = add_cy;
          cnt_d  = cnt_q + CNT_W'(1);
          zacc_d = zacc_q && (add_z == '0);
          pacc_d = pacc_q ^ (^add_z);
          // MS-word flags are captured at accept time; carry_q keeps the final carry-out.
          if (cnt_q == LAST_C) begin
            ms_sign_d = add_sign;
            ms_ovf_d  = add_ovf;
          end
        end else if (hshake) begin
          ov_d   = 1'b0;
          last_d = 1'b0;
        end
        if (hshake && last_q) begin
          state_d    = S_DONE;
          f_sign_d   = ms_sign_q;
          f_zero_d   = zacc_q;
          f_carry_d  = cy_q;
          f_parity_d = pacc_q;
          f_ovf_d    = ms_ovf_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cy_q       <= 1'b0;
      zacc_q     <= 1'b1;
      pacc_q     <= 1'b0;
      sum_q      <= '0;
      ov_q       <= 1'b0;
      last_q     <= 1'b0;
      ms_sign_q  <= 1'b0;
      ms_ovf_q   <= 1'b0;
      f_sign_q   <= 1'b0;
      f_zero_q   <= 1'b1;
      f_carry_q  <= 1'b0;
      f_parity_q <= 1'b0;
      f_ovf_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cy_q       <= cy_d;
      zacc_q     <= zacc_d;
      pacc_q     <= pacc_d;
      sum_q      <= sum_d;
      ov_q       <= ov_d;
      last_q     <= last_d;
      ms_sign_q  <= ms_sign_d;
      ms_ovf_q   <= ms_ovf_d;
      f_sign_q   <= f_sign_d;
      f_zero_q   <= f_zero_d;
      f_carry_q  <= f_carry_d;
      f_parity_q <= f_parity_d;
      f_ovf_q    <= f_ovf_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign sum_word  = sum_q;
  assign out_valid = ov_q;
  assign last      = last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign sign      = f_sign_q;
  assign zero      = f_zero_q;
  assign carry     = f_carry_q;
  assign parity    = f_parity_q;
  assign overflow  = f_ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq (NWORDS=4): directed corner operands, a stall,
// a mid-operation reset, then randomized operands with random downstream backpressure.
module tb_multiword_add_seq;

  logic        clk = 1'b0;
  logic        rst, start, cin_init, in_valid;
  logic        out_ready = 1'b1;
  logic [15:0] a_word, b_word, sum_word;
  logic        in_ready, out_valid, last, busy, done;
  logic        sign, zero, carry, parity, overflow;

  multiword_add_seq #(.NWORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cin_init(cin_init),
    .in_valid(in_valid), .in_ready(in_ready), .a_word(a_word), .b_word(b_word),
    .sum_word(sum_word), .out_valid(out_valid), .out_ready(out_ready), .last(last),
    .busy(busy), .done(done), .sign(sign), .zero(zero), .carry(carry),
    .parity(parity), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [15:0] w; logic l;} wexp_t;
  typedef struct packed {logic s; logic z; logic c; logic p; logic o;} fexp_t;

  wexp_t wq[$];
  fexp_t fq[$];
  int    total = 0;
  int    bad   = 0;
  bit    rand_ordy  = 1'b0;
  bit    ordy_force = 1'b1;
  bit    mon_ignore = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Downstream ready: random, or whatever the stimulus forces.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ordy ? ($urandom_range(0, 3) != 0) : ordy_force;
    end
  end

  // Monitor: compares every output handshake and every done pulse against the queues.
  initial begin
    bit          prev_stall = 1'b0;
    bit          pend_done  = 1'b0;
    bit          post_done  = 1'b0;
    logic [15:0] prev_sum   = '0;
    logic        prev_last  = 1'b0;
    wexp_t       we;
    fexp_t       fe;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        pend_done  = 1'b0;
        post_done  = 1'b0;
      end else begin
        if (post_done) begin
          check("post_done_idle", 64'({done, busy}), 64'd0);
          post_done = 1'b0;
        end
        if (pend_done) begin
          check("done_after_last", 64'(done), 64'd1);
          pend_done = 1'b0;
          if (done) begin
            post_done = 1'b1;
            if (fq.size() == 0) check("flag_queue_size", 64'(fq.size()), 64'd1);
            else begin
              fe = fq.pop_front();
              check("flags_szcpo", 64'({sign, zero, carry, parity, overflow}), 64'(fe));
            end
          end
        end else if (done) begin
          check("unexpected_done", 64'(done), 64'd0);
        end
        if (prev_stall && !mon_ignore)
          check("stall_hold", 64'({out_valid, last, sum_word}), 64'({1'b1, prev_last, prev_sum}));
        if (out_valid && !out_ready)
          check("stall_in_ready", 64'(in_ready), 64'd0);
        if (out_valid && out_ready && !mon_ignore) begin
          if (wq.size() == 0) check("word_queue_size", 64'(wq.size()), 64'd1);
          else begin
            we = wq.pop_front();
            check("sum_word", 64'(sum_word), 64'(we.w));
            check("last", 64'(last), 64'(we.l));
            if (we.l) pend_done = 1'b1;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum_word;
        prev_last  = last;
      end
    end
  end

  // One operation. stall_idx: word after whose accept out_ready is held low 3 cycles.
  // abort_idx: number of accepted words after which rst is pulsed (-1 = none).
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input int stall_idx, input int abort_idx);
    logic [64:0] tot;
    logic [63:0] res;
    int          guard;
    int          gap;
    bit          acc;
    if (abort_idx < 0) begin
      tot = {1'b0, a} + {1'b0, b} + 65'(cin);
      res = tot[63:0];
      for (int i = 0; i < 4; i++) wq.push_back({res[i*16 +: 16], (i == 3)});
      fq.push_back({res[63], (res == 64'd0), tot[64], ^res,
                    (a[63] == b[63]) && (res[63] != a[63])});
    end else begin
      mon_ignore = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b1; cin_init = cin;
    @(posedge clk); #1;
    start = 1'b0; cin_init = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rand_ordy) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk); #1; end
      end
      a_word = a[i*16 +: 16];
      b_word = b[i*16 +: 16];
      in_valid = 1'b1;
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        if (in_ready) acc = 1'b1;
        else begin @(posedge clk); #1; guard++; end
      end
      if (!acc) check("in_ready_wait", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i == stall_idx) begin
        ordy_force = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        ordy_force = 1'b1;
      end
      if (i + 1 == abort_idx) begin
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_ignore = 1'b0;
        return;
      end
    end
    guard = 0;
    while ((busy || wq.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) check("op_timeout_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;
    rst = 1'b0; start = 1'b0; cin_init = 1'b0; in_valid = 1'b0;
    a_word = '0; b_word = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum_word", 64'(sum_word), 64'd0);
    check("rst_last", 64'(last), 64'd0);
    check("rst_done_busy", 64'({done, busy}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_flags_szcpo", 64'({sign, zero, carry, parity, overflow}), 64'b01000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(64'h0, 64'h0, 1'b0, -1, -1);
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, -1, -1);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, -1, -1);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, -1, -1);
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1, -1);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, -1, 2);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, -1, -1);

    rand_ordy = 1'b1;
    for (int n = 0; n < 25; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        2: ra = 64'h7FFF_FFFF_FFFF_FFFF;
        3: rb = ~ra;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), -1, -1);
    end
    rand_ordy = 1'b0;
    repeat (5) @(negedge clk);
    check("words_drained", 64'(wq.size()), 64'd0);
    check("flags_drained", 64'(fq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4 (legal 2..8): number of 16-bit words per operand, least-significant word first.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: begins an operation when in IDLE.
REQ-005 SHALL have port cin_init, input, 1: carry-in for word 0, sampled with start.
REQ-006 SHALL have port in_valid, input, 1: a_word/b_word valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts an operand pair this cycle.
REQ-008 SHALL have ports a_word and b_word, input, 16 each: current operand words.
REQ-009 SHALL have port sum_word, output, 16: registered result word.
REQ-010 SHALL have port out_valid, output, 1: sum_word valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts sum_word.
REQ-012 SHALL have port last, output, 1: qualifies the most-significant result word.
REQ-013 SHALL have ports busy and done, output, 1 each: operation in progress; one-cycle completion pulse.
REQ-014 SHALL have ports sign, zero, carry, parity and overflow, output, 1 each: whole-result flags.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE.
REQ-016 IDLE -> RUN on start=1; SHALL load the carry register from cin_init, clear the word counter, set the zero accumulator to 1 and the parity accumulator to 0.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 in_ready SHALL be 1 only in RUN, with the counter below NWORDS, and with out_valid=0 or out_ready=1.
REQ-019 On in_valid and in_ready, SHALL compute a_word+b_word+carry and register it into sum_word, setting out_valid=1 on the next cycle (latency 1).
REQ-020 The same accept SHALL store carry-out as the next carry and increment the counter.
REQ-021 The same accept SHALL update zero_acc to zero_acc AND (sum==0) and parity_acc to parity_acc XOR ^sum.
REQ-022 last SHALL be 1 together with out_valid for the word produced by accept number NWORDS-1 (counter = NWORDS-1).
REQ-023 sum_word, out_valid and last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 out_valid SHALL clear after a handshake unless a new accept occurs in the same cycle; back-to-back throughput SHALL be one word per cycle.
REQ-025 RUN -> DONE SHALL occur on the handshake of the last word.
REQ-026 On RUN -> DONE, flags SHALL be registered as follows:
 - sign = bit 15 of the MS word
 - carry = carry-out of the MS word
 - overflow = signed overflow of the MS word add (operand signs equal, result sign differs)
 - zero = final zero_acc
 - parity = final parity_acc (1 = odd count of ones across the whole result)
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-028 Flags SHALL hold until the next DONE or reset.
REQ-029 busy SHALL be 1 in RUN and DONE.
REQ-030 in_valid with in_ready=0 SHALL be ignored: no state change, and the data is not consumed.
REQ-031 The carry chain SHALL be 16-bit with no truncation; the carry between words is exactly 1 bit.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE and clear to 0: counter, carry, sum_word, out_valid, last, done, busy, in_ready, sign, carry, parity and overflow.
REQ-033 rst=1 SHALL set zero to 1.
REQ-034 Reset mid-operation SHALL abandon the operation: no done pulse, and partial results are discarded.

Structure
REQ-035 State encoding and the word-width constant (16) SHALL reside in a shared package; NWORDS remains a module parameter.
REQ-036 Per-word addition SHALL be a single instance of the existing fullAdder_16bit module.
REQ-037 The adder's Z and Carry SHALL be used for the sum and inter-word carry, and its Sign, Carry and Overflow for the MS-word flags.
REQ-038 Zero and parity SHALL be accumulated locally.

Verification (NWORDS=4, operands written MS..LS)
REQ-039 0000_0000_0000_0000 + 0000_0000_0000_0000, cin_init=0 -> four words 0000, last on word 4, done one cycle later, zero=1, carry=0, overflow=0, sign=0, parity=0.
REQ-040 0000_0000_0000_FFFF + 0000_0000_0000_0001 -> words 0000, 0001, 0000, 0000; zero=0, carry=0, parity=1.
REQ-041 FFFF_FFFF_FFFF_FFFF + 0000_0000_0000_0001 -> all words 0000; carry=1, zero=1, overflow=0, sign=0.
REQ-042 7FFF_FFFF_FFFF_FFFF + 0000_0000_0000_0001 -> result 8000_0000_0000_0000; overflow=1, sign=1, carry=0, parity=1.
REQ-043 out_ready held low 3 cycles while word 2 is valid -> in_ready=0, sum_word/last stable, no words lost; result matches REQ-040.
REQ-044 rst pulsed after 2 accepted words -> immediate IDLE, out_valid=0, no done; a following REQ-041 run completes correctly.
